reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 134 +++++++++++++
 tb/tb_reg_dump.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register-file dump engine: walks indices FIRST_IDX..LAST_IDX and streams each word out over a valid/ready port.
// Optional feature macro REG_DUMP_CHECKSUM_EN appends one XOR-checksum beat (idx 0, last=1) to every dump.
module reg_dump #(
  parameter int FIRST_IDX = 0,
  parameter int LAST_IDX  = 31
) (
  input  logic        clkin,
  input  logic        rst_in,
  input  logic        start_in,
  output logic [4:0]  rd_idx_out,
  input  logic [31:0] rd_data_in,
  output logic [31:0] dout_data_out,
  output logic [4:0]  dout_idx_out,
  output logic        dout_last_out,
  output logic        dout_valid_out,
  input  logic        dout_ready_in,
  output logic        busy_out,
  output logic        done_out
);

  localparam logic [4:0] C_FIRST = 5'(FIRST_IDX);
  localparam logic [4:0] C_LAST  = 5'(LAST_IDX);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_SEND = 2'd2, S_CSUM = 2'd3} state_t;
  logic [31:0] r_acc;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_SEND = 2'd2} state_t;
`endif

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_data;
  logic [4:0]  r_idx;
  logic        r_last;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        w_accept;

  assign w_accept       = r_valid & dout_ready_in;
  assign rd_idx_out     = r_cnt;
  assign dout_data_out  = r_data;
  assign dout_idx_out   = r_idx;
  assign dout_last_out  = r_last;
  assign dout_valid_out = r_valid;
  assign busy_out       = r_busy;
  assign done_out       = r_done;

  // Dump sequencer: every output is a register, so beats stay frozen while the sink stalls.
  always_ff @(posedge clkin) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= C_FIRST;
      r_data  <= 32'd0;
      r_idx   <= 5'd0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_acc   <= 32'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_cnt   <= C_FIRST;
            r_busy  <= 1'b1;
            r_state <= S_READ;
`ifdef REG_DUMP_CHECKSUM_EN
            r_acc   <= 32'd0;
`endif
          end
        end
        S_READ: begin
          r_data  <= rd_data_in;
          r_idx   <= r_cnt;
          r_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          r_last  <= 1'b0;
          r_acc   <= r_acc ^ rd_data_in;
`else
          r_last  <= (r_cnt == C_LAST);
`endif
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_accept) begin
            if (r_cnt < C_LAST) begin
              r_cnt   <= r_cnt + 5'd1;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_READ;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Accumulator already holds the final word; valid stays high for the checksum beat.
              r_data  <= r_acc;
              r_idx   <= 5'd0;
              r_last  <= 1'b1;
              r_state <= S_CSUM;
`else
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
`endif
        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: beats captured by a monitor are compared with a transaction-level model of the dump.
// Define REG_DUMP_CHECKSUM_EN for both bench and RTL to exercise the checksum beat.
module tb_reg_dump;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int FIRST = 0;
  localparam int LAST  = 31;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic [4:0]  rd_idx, idx;
  logic [31:0] rd_data, data;
  logic        last, valid, busy, done;
  logic        start2, ready2;
  logic [4:0]  rd_idx2, idx2;
  logic [31:0] rd_data2, data2;
  logic        last2, valid2, busy2, done2;

  logic [31:0] mem [32];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  beat_t       got_q[$];
  int          done_q[$];

  always #5 clk = ~clk;

  assign rd_data  = mem[rd_idx];
  assign rd_data2 = mem[rd_idx2];

  reg_dump #(.FIRST_IDX(FIRST), .LAST_IDX(LAST)) dut (
    .clkin(clk), .rst_in(rst), .start_in(start), .rd_idx_out(rd_idx), .rd_data_in(rd_data),
    .dout_data_out(data), .dout_idx_out(idx), .dout_last_out(last), .dout_valid_out(valid),
    .dout_ready_in(ready), .busy_out(busy), .done_out(done)
  );

  reg_dump #(.FIRST_IDX(5), .LAST_IDX(5)) dut_one (
    .clkin(clk), .rst_in(rst), .start_in(start2), .rd_idx_out(rd_idx2), .rd_data_in(rd_data2),
    .dout_data_out(data2), .dout_idx_out(idx2), .dout_last_out(last2), .dout_valid_out(valid2),
    .dout_ready_in(ready2), .busy_out(busy2), .done_out(done2)
  );

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: a beat is recorded in the cycle where valid and ready meet
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) got_q.push_back('{idx, data, last, cyc});
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b1; start2 = 1'b0; ready2 = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        data !== 32'd0 || idx !== 5'd0 || rd_idx !== 5'd0)
      $display("FAIL reset_main: got v%b l%b b%b d%b data %h idx %0d rd %0d want all 0",
               valid, last, busy, done, data, idx, rd_idx);
    else n_pass++;
    n_checks++;
    if (valid2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 || rd_idx2 !== 5'd5)
      $display("FAIL reset_single: got v%b b%b d%b rd %0d want 0 0 0 5", valid2, busy2, done2, rd_idx2);
    else n_pass++;
    rst = 1'b0;
  endtask

  // mode 0: ready=1, mode 1: stall 5 cycles on idx 7, mode 2: random ready
  task automatic run_dump(input int mode, input bit mid_start, input bit chain, input string name);
    int          gb, db, n_exp, stall, per;
    bit          timeout, hold;
    logic [31:0] pd, x;
    logic [4:0]  pi;
    logic        pl;
    beat_t       exp_q[$];
    gb = got_q.size(); db = done_q.size(); n_exp = chain ? 2 : 1;
    stall = 0; timeout = 1'b1; hold = 1'b0; pd = 32'd0; pi = 5'd0; pl = 1'b0;
    @(posedge clk); #1; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (hold) begin
        n_checks++;
        if (valid !== 1'b1 || data !== pd || idx !== pi || last !== pl)
          $display("FAIL %s_stall_stable: got v%b %h idx %0d l%b want v1 %h idx %0d l%b",
                   name, valid, data, idx, last, pd, pi, pl);
        else n_pass++;
      end
      start = ((chain && done && done_q.size() == db) || (mid_start && k == 20)) ? 1'b1 : 1'b0;
      case (mode)
        1: begin
          if (valid && idx == 5'd7 && stall < 5) begin ready = 1'b0; stall++; end
          else ready = 1'b1;
        end
        2: ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
      hold = valid && !ready; pd = data; pi = idx; pl = last;
      @(posedge clk); #1;
      if (done_q.size() - db >= n_exp) begin timeout = 1'b0; break; end
    end
    start = 1'b0; ready = 1'b1;
    n_checks++;
    if (timeout) $display("FAIL %s_timeout: got %0d done pulses want %0d", name, done_q.size() - db, n_exp);
    else n_pass++;

    for (int d = 0; d < n_exp; d++) begin
      x = 32'd0;
      for (int i = FIRST; i <= LAST; i++) begin
        exp_q.push_back('{5'(i), mem[i], (!CSUM && i == LAST), 0});
        x ^= mem[i];
      end
      if (CSUM) exp_q.push_back('{5'd0, x, 1'b1, 0});
    end
    per = exp_q.size() / n_exp;

    n_checks++;
    if (got_q.size() - gb != exp_q.size())
      $display("FAIL %s_beat_count: got %0d want %0d", name, got_q.size() - gb, exp_q.size());
    else n_pass++;
    for (int j = 0; j < exp_q.size() && gb + j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[gb+j].idx !== exp_q[j].idx || got_q[gb+j].data !== exp_q[j].data ||
          got_q[gb+j].last !== exp_q[j].last)
        $display("FAIL %s_beat%0d: got idx %0d %h l%b want idx %0d %h l%b", name, j,
                 got_q[gb+j].idx, got_q[gb+j].data, got_q[gb+j].last,
                 exp_q[j].idx, exp_q[j].data, exp_q[j].last);
      else n_pass++;
      if (mode == 0 && (j % per) != 0) begin
        int gap;
        gap = (CSUM && (j % per) == per - 1) ? 1 : 2;
        n_checks++;
        if (got_q[gb+j].cyc - got_q[gb+j-1].cyc != gap)
          $display("FAIL %s_spacing%0d: got %0d want %0d", name, j, got_q[gb+j].cyc - got_q[gb+j-1].cyc, gap);
        else n_pass++;
      end
    end
    n_checks++;
    if (done_q.size() - db != n_exp)
      $display("FAIL %s_done_count: got %0d want %0d", name, done_q.size() - db, n_exp);
    else n_pass++;
    for (int d = 0; d < n_exp; d++) begin
      if (db + d < done_q.size() && gb + (d + 1) * per - 1 < got_q.size()) begin
        n_checks++;
        if (done_q[db+d] != got_q[gb+(d+1)*per-1].cyc + 1)
          $display("FAIL %s_done_timing%0d: got cycle %0d want %0d", name, d, done_q[db+d],
                   got_q[gb+(d+1)*per-1].cyc + 1);
        else n_pass++;
      end
    end
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL %s_idle_after: got busy %b valid %b want 0 0", name, busy, valid);
    else n_pass++;
    if (mode == 1) begin
      n_checks++;
      if (stall != 5) $display("FAIL %s_stall_cycles: got %0d want 5", name, stall);
      else n_pass++;
    end
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    run_dump(0, 1'b0, 1'b0, "full");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    run_dump(1, 1'b0, 1'b0, "stall7");
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    run_dump(2, 1'b0, 1'b0, "rand_ready");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    run_dump(0, 1'b1, 1'b1, "b2b");
  endtask

  task automatic test_reset_mid();
    int  k;
    bit  found;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    found = 1'b0;
    @(posedge clk); #1; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (valid && idx == 5'd12) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!found) $display("FAIL rst_mid_reach: got no idx 12 beat want one");
    else n_pass++;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        data !== 32'd0 || idx !== 5'd0 || rd_idx !== 5'd0)
      $display("FAIL rst_mid_outputs: got v%b l%b b%b d%b %h idx %0d rd %0d want all 0",
               valid, last, busy, done, data, idx, rd_idx);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_quiet%0d: got done %b busy %b want 0 0", c, done, busy);
      else n_pass++;
      @(posedge clk); #1;
    end
    run_dump(0, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_single();
    bit found;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    found = 1'b0; ready2 = 1'b0;
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (valid2) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!found || idx2 !== 5'd5 || data2 !== mem[5] || last2 !== !CSUM)
      $display("FAIL single_beat: got v%b idx %0d %h l%b want v1 idx 5 %h l%b", valid2, idx2, data2, last2, mem[5], !CSUM);
    else n_pass++;
    ready2 = 1'b1;
    @(posedge clk); #1;
    if (CSUM) begin
      n_checks++;
      if (valid2 !== 1'b1 || idx2 !== 5'd0 || data2 !== mem[5] || last2 !== 1'b1)
        $display("FAIL single_csum: got v%b idx %0d %h l%b want v1 idx 0 %h l1", valid2, idx2, data2, last2, mem[5]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (done2 !== 1'b1 || valid2 !== 1'b0 || busy2 !== 1'b0)
      $display("FAIL single_done: got done %b valid %b busy %b want 1 0 0", done2, valid2, busy2);
    else n_pass++;
    ready2 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done2 !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", done2);
    else n_pass++;
  endtask

  task automatic test_checksum();
    int gb;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    gb = got_q.size();
    run_dump(0, 1'b0, 1'b0, "csum_idx");
    if (CSUM) begin
      n_checks++;
      if (got_q.size() < gb + 33 || got_q[gb+32].data !== 32'h0000_0000)
        $display("FAIL csum_idx_value: got %0d beats want 33 with checksum 00000000", got_q.size() - gb);
      else n_pass++;
    end
    for (int i = 0; i < 32; i++) mem[i] = 32'd1 << i;
    gb = got_q.size();
    run_dump(0, 1'b0, 1'b0, "csum_onehot");
    if (CSUM) begin
      n_checks++;
      if (got_q.size() < gb + 33 || got_q[gb+32].data !== 32'hFFFF_FFFF)
        $display("FAIL csum_onehot_value: got %0d beats want 33 with checksum ffffffff", got_q.size() - gb);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_stall();
    test_random_ready();
    test_back_to_back();
    test_reset_mid();
    test_single();
    test_checksum();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
